// File: rtl/ws2811_decoder_pkg.sv
// Shared timing constants, derived cycle counts and strobe FSM states for the WS2811 receiver.
`timescale 1ns/1ps
package ws2811_decoder_pkg;

  localparam int unsigned CLK_FREQ_HZ    = 133_000_000;
  localparam int unsigned T_THRESH_NS    = 425;
  localparam int unsigned T_GLITCH_NS    = 80;
  localparam int unsigned T_IDLE_NS      = 20_000;
  localparam int unsigned DATACLK_CYCLES = 2;

  // Convert a duration in ns to masterClk cycles, rounding up.
  function automatic int unsigned ns_to_cyc(input longint unsigned ns,
                                            input longint unsigned freq_hz);
    longint unsigned prod;
    prod = ns * freq_hz + 64'd999_999_999;
    return 32'(prod / 64'd1_000_000_000);
  endfunction

  localparam int unsigned THRESH_CYC = ns_to_cyc(64'(T_THRESH_NS), 64'(CLK_FREQ_HZ));
  localparam int unsigned GLITCH_CYC = ns_to_cyc(64'(T_GLITCH_NS), 64'(CLK_FREQ_HZ));
  localparam int unsigned IDLE_CYC   = ns_to_cyc(64'(T_IDLE_NS), 64'(CLK_FREQ_HZ));
  localparam int unsigned CNT_W      = $clog2(IDLE_CYC + 1);

  // dataClk high-time counter width (at least one bit).
  localparam int unsigned DCLK_CNT_W = (DATACLK_CYCLES > 1) ? $clog2(DATACLK_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_HOLD  = 2'd3
  } strobe_state_e;

endpackage

// File: rtl/ws2811_decoder_if.sv
// Serial line in, decoded bit / strobe / frame flag out.
`timescale 1ns/1ps
interface ws2811_decoder_if;
  logic dataIn;
  logic dataOut;
  logic dataClk;
  logic active;

  modport master (output dataIn, input dataOut, input dataClk, input active);
  modport slave  (input dataIn, output dataOut, output dataClk, output active);
endinterface

// File: rtl/ws2811_decoder_sync_2ff.sv
// Two-flop synchroniser for the asynchronous serial line.
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_q1;
  logic r_q2;

  // Metastability filter chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule

// File: rtl/ws2811_decoder.sv
// WS2811 receiver: decodes pulse widths into bits with a dataClk strobe and a frame-active flag.
`timescale 1ns/1ps
module ws2811_decoder
  import ws2811_decoder_pkg::*;
(
  input  logic              masterClk,
  input  logic              nReset,
  ws2811_decoder_if.slave   bus
);

  localparam logic [CNT_W-1:0]      THRESH_C = CNT_W'(THRESH_CYC);
  localparam logic [CNT_W-1:0]      GLITCH_C = CNT_W'(GLITCH_CYC);
  localparam logic [CNT_W-1:0]      IDLE_C   = CNT_W'(IDLE_CYC);
  localparam logic [DCLK_CNT_W-1:0] DCLK_END = DCLK_CNT_W'(DATACLK_CYCLES - 1);

  logic                  w_sync;
  logic                  r_sync_d;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_decode;
  logic [CNT_W-1:0]      r_hi_cnt;
  logic [CNT_W-1:0]      r_lo_cnt;
  logic                  r_data_out;
  logic                  r_data_clk;
  logic                  r_active;
  logic [DCLK_CNT_W-1:0] r_clk_cnt;
  strobe_state_e         r_state;
  strobe_state_e         w_next_state;

  sync_2ff u_sync (
    .clk   (masterClk),
    .rst_n (nReset),
    .i_d   (bus.dataIn),
    .o_q   (w_sync)
  );

  assign w_rise   = w_sync & ~r_sync_d;
  assign w_fall   = ~w_sync & r_sync_d;
  assign w_decode = w_fall && (r_hi_cnt >= GLITCH_C);

  // Edge-detect delay of the synchronised line.
  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset) r_sync_d <= 1'b0;
    else         r_sync_d <= w_sync;
  end

  // High-time counter: restarts on a rising edge, counts while high, saturates.
  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset)                      r_hi_cnt <= '0;
    else if (w_rise)                  r_hi_cnt <= CNT_W'(1);
    else if (w_sync && ~&r_hi_cnt)    r_hi_cnt <= r_hi_cnt + CNT_W'(1);
  end

  // Low-time counter: cleared by any rising edge, counts while low, saturates.
  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset)                      r_lo_cnt <= '0;
    else if (w_rise)                  r_lo_cnt <= '0;
    else if (!w_sync && ~&r_lo_cnt)   r_lo_cnt <= r_lo_cnt + CNT_W'(1);
  end

  // Decoded bit, held until the next accepted pulse.
  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset)       r_data_out <= 1'b0;
    else if (w_decode) r_data_out <= (r_hi_cnt >= THRESH_C);
  end

  // Frame flag: set once a high pulse outlasts the glitch window, cleared after idle low time.
  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset)                             r_active <= 1'b0;
    else if (r_sync_d && r_hi_cnt >= GLITCH_C) r_active <= 1'b1;
    else if (r_lo_cnt >= IDLE_C)             r_active <= 1'b0;
  end

  // Strobe FSM state register.
  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Strobe FSM: setup cycle, DATACLK_CYCLES high, one hold cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_IDLE;
      S_SETUP: w_next_state = S_HIGH;
      S_HIGH:  if (r_clk_cnt == DCLK_END) w_next_state = S_HOLD;
      S_HOLD:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (w_decode) w_next_state = S_SETUP;
  end

  // dataClk high-time counter and registered strobe output.
  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset) begin
      r_clk_cnt  <= '0;
      r_data_clk <= 1'b0;
    end else begin
      r_clk_cnt  <= (r_state == S_HIGH) ? r_clk_cnt + DCLK_CNT_W'(1) : '0;
      r_data_clk <= (w_next_state == S_HIGH);
    end
  end

  assign bus.dataOut = r_data_out;
  assign bus.dataClk = r_data_clk;
  assign bus.active  = r_active;

endmodule

// File: tb/tb_ws2811_decoder.sv
// Directed bench for ws2811_decoder: byte table across skews plus corner-case sequences.
`timescale 1ns/1ps
module tb_ws2811_decoder;

  logic masterClk;
  logic nReset;
  ws2811_decoder_if bus();

  ws2811_decoder dut (
    .masterClk (masterClk),
    .nReset    (nReset),
    .bus       (bus)
  );

  initial masterClk = 1'b0;
  always #3.759 masterClk = ~masterClk;

  int n_vec = 0;
  int n_err = 0;
  int strobes = 0;
  int s0;
  logic [7:0] shift_q = 8'h00;

  // Downstream shift register model clocked by dataClk.
  always @(posedge bus.dataClk) begin
    shift_q = {shift_q[6:0], bus.dataOut};
    strobes = strobes + 1;
  end

  typedef struct {
    logic [7:0] din;
    int         skew;
    bit         idle_after;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input bit b, input int skew);
    int th;
    th = (b ? 600 : 250) + skew;
    bus.dataIn = 1'b1;
    #(th);
    bus.dataIn = 1'b0;
    #(1240 - th);
  endtask

  task automatic send_byte(input logic [7:0] v, input int skew);
    for (int i = 7; i >= 0; i--) send_bit(v[i], skew);
  endtask

  // High pulse of exactly n clock cycles, driven away from the sampling edge.
  task automatic pulse_cycles(input int n);
    @(negedge masterClk);
    bus.dataIn = 1'b1;
    repeat (n) @(negedge masterClk);
    bus.dataIn = 1'b0;
    repeat (40) @(negedge masterClk);
  endtask

  initial begin
    vecs[0]  = '{8'h55,    0, 1'b0, 8'h55};
    vecs[1]  = '{8'hAA,    0, 1'b0, 8'hAA};
    vecs[2]  = '{8'h00,    0, 1'b0, 8'h00};
    vecs[3]  = '{8'hFF,    0, 1'b1, 8'hFF};
    vecs[4]  = '{8'h55,  150, 1'b0, 8'h55};
    vecs[5]  = '{8'hAA,  150, 1'b0, 8'hAA};
    vecs[6]  = '{8'h00,  150, 1'b0, 8'h00};
    vecs[7]  = '{8'hFF,  150, 1'b1, 8'hFF};
    vecs[8]  = '{8'h55, -150, 1'b0, 8'h55};
    vecs[9]  = '{8'hAA, -150, 1'b0, 8'hAA};
    vecs[10] = '{8'h00, -150, 1'b0, 8'h00};
    vecs[11] = '{8'hFF, -150, 1'b1, 8'hFF};

    bus.dataIn = 1'b0;
    nReset = 1'b1;
    #5 nReset = 1'b0;
    #50;
    check("rst_dataOut", 32'(bus.dataOut), 32'd0);
    check("rst_dataClk", 32'(bus.dataClk), 32'd0);
    check("rst_active",  32'(bus.active),  32'd0);
    #50 nReset = 1'b1;
    #200;

    // Garbage frame, then idle.
    send_byte(8'hF0, 0);
    #300;
    check("garbage_byte", 32'(shift_q), 32'h0F0);
    #22000;
    check("garbage_idle_active", 32'(bus.active), 32'd0);

    // Byte table across nominal and skewed timing.
    for (int v = 0; v < 12; v++) begin
      s0 = strobes;
      send_byte(vecs[v].din, vecs[v].skew);
      #300;
      check($sformatf("vec%0d_byte", v),    32'(shift_q), 32'(vecs[v].exp_byte));
      check($sformatf("vec%0d_strobes", v), 32'(strobes - s0), 32'd8);
      check($sformatf("vec%0d_active", v),  32'(bus.active), 32'd1);
      if (vecs[v].idle_after) begin
        #22000;
        check($sformatf("vec%0d_idle_active", v), 32'(bus.active), 32'd0);
      end
    end

    // Long idle after the -150 ns frame: nothing more happens.
    s0 = strobes;
    #50000;
    check("long_idle_active",  32'(bus.active), 32'd0);
    check("long_idle_byte",    32'(shift_q), 32'h0FF);
    check("long_idle_strobes", 32'(strobes - s0), 32'd0);

    // Cycle-exact threshold and glitch boundaries.
    s0 = strobes;
    pulse_cycles(56);
    check("thresh_m1_bit", 32'(bus.dataOut), 32'd0);
    pulse_cycles(11);
    check("glitch_eq_bit", 32'(bus.dataOut), 32'd0);
    check("glitch_eq_strobes", 32'(strobes - s0), 32'd2);
    pulse_cycles(57);
    check("thresh_eq_bit", 32'(bus.dataOut), 32'd1);
    s0 = strobes;
    pulse_cycles(10);
    check("glitch_m1_strobes", 32'(strobes - s0), 32'd0);
    check("glitch_m1_bit", 32'(bus.dataOut), 32'd1);

    // 40 ns glitch inside the low phase of a '1' bit.
    s0 = strobes;
    bus.dataIn = 1'b1; #600;
    bus.dataIn = 1'b0; #300;
    bus.dataIn = 1'b1; #40;
    bus.dataIn = 1'b0; #300;
    check("lowglitch_strobes", 32'(strobes - s0), 32'd1);
    check("lowglitch_bit",     32'(bus.dataOut), 32'd1);
    check("lowglitch_active",  32'(bus.active), 32'd1);
    #22000;

    // Reset in the middle of a byte.
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    check("prerst_bit", 32'(bus.dataOut), 32'd1);
    bus.dataIn = 1'b1;
    #300;
    nReset = 1'b0;
    #1;
    check("midrst_dataOut", 32'(bus.dataOut), 32'd0);
    check("midrst_dataClk", 32'(bus.dataClk), 32'd0);
    check("midrst_active",  32'(bus.active),  32'd0);
    #400 bus.dataIn = 1'b0;
    #1000 nReset = 1'b1;
    #1000;
    s0 = strobes;
    send_byte(8'hA5, 0);
    #300;
    check("postrst_byte",    32'(shift_q), 32'h0A5);
    check("postrst_strobes", 32'(strobes - s0), 32'd8);

    // Idle gap just under and just over the timeout (measured after the last bit slot).
    send_byte(8'hC3, 0);
    #19000;
    check("gap_short_active", 32'(bus.active), 32'd1);
    send_byte(8'h81, 0);
    #300;
    check("gap_short_byte", 32'(shift_q), 32'h081);
    #20700;
    check("gap_long_active", 32'(bus.active), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
